result_drain_ctrl: RTL and testbench

//  Read-side controller for the results SRAM. The systolic array writes de-skewed result rows into that SRAM.
//  On start, this block reads num_words consecutive rows from base_addr and streams them to the host.

---
 rtl/result_drain_ctrl.sv | 126 ++++++++++++
 tb/tb_result_drain_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain_ctrl.sv
// ============================================================================
// Module   : result_drain_ctrl
// Brief    : Drains consecutive rows of the results SRAM to a valid/ready
//            host stream through a 2-entry buffer that hides the read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_drain_ctrl #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int WORD_W         = PARTIAL_SUM_BW * MATRIX_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_rd_en,
  output logic [ADDRESSSIZE-1:0] sram_address,
  input  logic [WORD_W-1:0]      sram_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_data,
  output logic                   out_last
);

  localparam logic [ADDRESSSIZE-1:0] c_one = ADDRESSSIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDRESSSIZE-1:0] r_addr;
  logic [ADDRESSSIZE-1:0] r_remaining;
  logic [ADDRESSSIZE-1:0] r_num;
  logic [ADDRESSSIZE-1:0] r_sent;
  logic                   r_inflight;
  logic [WORD_W-1:0]      r_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic                   w_pop;
  logic [1:0]             w_occ;
  logic                   w_issue;

  assign w_pop   = out_valid & out_ready;
  // Slots that will be taken once this cycle's pop retires; a new read may
  // only be issued if it is guaranteed a free slot when its data lands.
  assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue = (r_state == S_READ) && (w_occ < 2'd2);

  assign sram_rd_en   = w_issue;
  assign sram_address = r_addr;
  assign busy         = (r_state == S_READ) || (r_state == S_FLUSH);
  assign done         = (r_state == S_DONE);
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_mem[r_rd_ptr];
  assign out_last     = out_valid && (r_sent == (r_num - c_one));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_num       <= '0;
      r_sent      <= '0;
      r_inflight  <= 1'b0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= sram_data_in;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_sent   <= r_sent + c_one;
      end
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr      <= r_addr + c_one;
        r_remaining <= r_remaining - c_one;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              r_state     <= S_READ;
              r_addr      <= base_addr;
              r_remaining <= num_words;
              r_num       <= num_words;
              r_sent      <= '0;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (w_issue && (r_remaining == c_one)) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_pop && out_last) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_drain_ctrl.sv
// ============================================================================
// Module   : tb_result_drain_ctrl
// Brief    : Scoreboard bench for result_drain_ctrl with an SRAM read model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_drain_ctrl;

  localparam int AW = 10;
  localparam int WW = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_words;
  logic          busy;
  logic          done;
  logic          sram_rd_en;
  logic [AW-1:0] sram_address;
  logic [WW-1:0] sram_data_in = '0;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          out_last;

  result_drain_ctrl #(
    .ADDRESSSIZE(10), .PARTIAL_SUM_BW(20), .MATRIX_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .sram_rd_en(sram_rd_en), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [WW-1:0] got,
                       input logic [WW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [WW-1:0] row(input logic [AW-1:0] a);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*20 +: 20] = {a, 3'(i), 7'h55 ^ a[6:0]};
    return r;
  endfunction

  // SRAM: one-cycle read latency
  always @(posedge clk) if (sram_rd_en) sram_data_in <= row(sram_address);

  logic [AW-1:0] addr_q [$];
  logic [WW-1:0] exp_q  [$];
  logic          last_q [$];
  int            n_issued = 0;
  int            n_popped = 0;
  int            ready_mode = 0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data;
  logic          prev_last;

  initial begin
    int rc;
    rc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_rd_en) begin
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", sram_address, addr_q.pop_front());
        check("outstanding_le2",
              ((n_issued - n_popped - ((out_valid && out_ready) ? 1 : 0) + 1) <= 2), 1);
        n_issued++;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_last", out_last, last_q.pop_front());
        end
        n_popped++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic expect_drain(input logic [AW-1:0] base, input logic [AW-1:0] num);
    logic [AW-1:0] a;
    n_issued = 0;
    n_popped = 0;
    for (int k = 0; k < int'(num); k++) begin
      a = base + AW'(k);
      addr_q.push_back(a);
      exp_q.push_back(row(a));
      last_q.push_back(k == int'(num) - 1);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input logic [AW-1:0] num);
    start = 1'b1; base_addr = base; num_words = num;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_drain(input logic [AW-1:0] base, input logic [AW-1:0] num,
                           input int mode, input bit restart);
    bit got;
    ready_mode = mode;
    expect_drain(base, num);
    @(posedge clk); #1;
    pulse_start(base, num);
    if (restart) begin
      repeat (2) @(posedge clk);
      #1;
      pulse_start(10'h200, 10'd3);
    end
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1);
    check("words_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    @(negedge clk);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    bit got;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", sram_rd_en, 0);
    check("rst_addr", sram_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // exact cycle timing, full throughput
    ready_mode = 0;
    expect_drain(10'h010, 10'd4);
    @(posedge clk); #1;
    pulse_start(10'h010, 10'd4);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      if (cyc > 1) @(posedge clk);
      @(negedge clk);
      check($sformatf("t1_rd_en_c%0d", cyc), sram_rd_en, (cyc <= 4));
      check($sformatf("t1_valid_c%0d", cyc), out_valid, (cyc >= 3 && cyc <= 6));
      check($sformatf("t1_last_c%0d", cyc), out_last, (cyc == 6));
      check($sformatf("t1_done_c%0d", cyc), done, (cyc == 7));
      check($sformatf("t1_busy_c%0d", cyc), busy, (cyc <= 6));
    end
    check("t1_words_left", exp_q.size(), 0);

    // backpressure 1,0,0 pattern
    run_drain(10'h010, 10'd4, 1, 1'b0);
    // address wrap
    run_drain(10'h3FE, 10'd4, 0, 1'b0);

    // zero-length request
    @(posedge clk); #1;
    pulse_start(10'h050, 10'd0);
    @(negedge clk);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_rd_en", sram_rd_en, 0);
    check("z_valid", out_valid, 0);
    @(negedge clk);
    check("z_done_clear", done, 0);

    // restart ignored mid-drain
    run_drain(10'h120, 10'd8, 2, 1'b1);

    // reset mid-drain
    ready_mode = 0;
    expect_drain(10'h080, 10'd8);
    @(posedge clk); #1;
    pulse_start(10'h080, 10'd8);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (n_popped >= 2) begin got = 1'b1; break; end
    end
    check("r_two_words", got, 1);
    rst = 1'b1;
    addr_q.delete(); exp_q.delete(); last_q.delete();
    @(negedge clk);
    check("r_busy", busy, 0);
    check("r_done", done, 0);
    check("r_rd_en", sram_rd_en, 0);
    check("r_addr", sram_address, 0);
    check("r_valid", out_valid, 0);
    check("r_last", out_last, 0);
    check("r_data", out_data, 0);
    rst = 1'b0;
    run_drain(10'h100, 10'd5, 2, 1'b0);
    run_drain(10'h3F0, 10'd20, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
